encode_inst: RTL and testbench
==============================

Name: encode_inst

Overview:
- RV32I instruction encoder: the inverse of the instruction decoder.
- Accepts decoded fields (op class, function code, register indices, immediate) over a valid/ready handshake.
- Packs them into 32-bit RV32I instruction words and buffers results in a 2-entry output FIFO.
- Used by the self-check bench and by the instruction-memory preload path to generate programs from field-level descriptions.

Parameters:
DEPTH, 2, output FIFO entries (power of two, >=2)
CNT_W, 16, width of accepted-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept (FIFO not full)
op_class  in  4  0 R-ALU, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC; others illegal
funct  in  4  ALU: 0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND; LOAD: 0 LB,1 LH,2 LW,4 LBU,5 LHU; STORE: 0 SB,1 SH,2 SW; BRANCH: funct3 value (0,1,4,5,6,7)
rd  in  5  destination register
rs1  in  5  source register 1
rs2  in  5  source register 2
imm  in  32  immediate as a full byte offset/value, sign-extended
out_valid  out  1  encoded word available
out_ready  in  1  consumer accepts word
out_inst  out  32  encoded instruction
out_err  out  1  entry came from an illegal field combination
inst_cnt  out  CNT_W  number of bundles accepted since reset

Behaviour:
- Accept when in_valid && in_ready; pop when out_valid && out_ready.
- Encoding is combinational at accept and written into the FIFO. Latency is 1 cycle: out_valid rises the cycle after the accept into an empty FIFO.
- in_ready = !full. No pass-through when full, even if a pop occurs in the same cycle.
- Simultaneous push and pop when neither full nor empty: occupancy unchanged, order preserved.
- Field packing:
  - Opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111 (funct3 000), LUI 0110111, AUIPC 0010111.
  - R: funct7 = 0100000 for SUB/SRA, else 0000000.
  - I: imm[11:0] -> [31:20].
  - I-shifts: [31:25] = funct7, [24:20] = imm[4:0].
  - S: imm[11:5] -> [31:25], imm[4:0] -> [11:7].
  - B: imm[12] -> [31], imm[10:5] -> [30:25], imm[4:1] -> [11:8], imm[11] -> [7]; imm[0] ignored.
  - U: imm[31:12] -> [31:12].
  - J: imm[20] -> [31], imm[10:1] -> [30:21], imm[11] -> [20], imm[19:12] -> [19:12].
  - Unused field positions are 0: rs2 for I-type, rd for S/B, rs1/rs2 for U/J.
- Illegal cases: op_class > 8, I-ALU with SUB, undefined LOAD/STORE/BRANCH funct, funct > 9 for ALU classes.
  - Illegal bundles are still accepted and counted.
  - Stored word is 32'h0000_0013 (NOP) with out_err = 1.
- inst_cnt increments on every accept and wraps from 2^CNT_W-1 to 0.
- Reset values: FIFO empty, out_valid 0, out_inst 0, out_err 0, inst_cnt 0, in_ready 1 from the first cycle after reset deasserts.
- Reset mid-operation flushes all buffered entries without emitting them.
- out_inst/out_err are held stable while out_valid && !out_ready.

Optional Feature:
- Macro: ENCODE_INST_RANGE_CHECK_EN.
- When defined, an immediate that does not fit its format also sets out_err = 1 and stores the NOP. Out-of-range conditions:
  - I/S outside -2048..2047.
  - B outside -4096..4094, or odd.
  - J outside +-1 MiB, or odd.
  - U with imm[11:0] != 0.
  - Shamt > 31.
- When not defined, immediates are silently truncated to the format's bits and out_err reflects only field-combination illegality.

Decomposition:
- Package encode_inst_pkg holds:
  - op_class and funct constants.
  - The 7-bit opcode constants.
  - The NOP constant.
  - Per-format immediate pack functions.
- One sub-module, inst_fifo (DEPTH x 33 bits: word + err, synchronous active-low reset), holds the buffering.
- The encoder proper is combinational logic plus the counter.

Test Plan:
- R-ALU SUB, rd=3 rs1=2 rs2=1 -> out_inst 0x401101B3 one cycle after accept, out_err 0.
- R-ALU OR, rd=9 rs1=1 rs2=2 -> 0x0020E4B3.
- LUI, rd=25 imm=0xBF45F000 -> 0xBF45FCB7.
- Backpressure: hold out_ready=0 and push 3 bundles -> in_ready drops after 2 accepts and inst_cnt=2. Raise out_ready -> words emerge in order and the third is accepted next.
- Illegal: op_class=9, then I-ALU funct=1 -> each yields 0x00000013 with out_err=1, and inst_cnt increments for both.
- Assert rst_n=0 for 1 cycle with 2 entries buffered -> out_valid=0, inst_cnt=0 next cycle, nothing further emitted. With ENCODE_INST_RANGE_CHECK_EN, I-ALU ADD imm=2048 -> NOP with out_err=1.

Source files
------------

// File: rtl/encode_inst_pkg.sv
// Shared constants and field-packing helpers for the RV32I instruction encoder.
// Range-check helpers are used only when ENCODE_INST_RANGE_CHECK_EN is defined.
package encode_inst_pkg;

  localparam logic [3:0] OP_R_ALU  = 4'd0;
  localparam logic [3:0] OP_I_ALU  = 4'd1;
  localparam logic [3:0] OP_LOAD   = 4'd2;
  localparam logic [3:0] OP_STORE  = 4'd3;
  localparam logic [3:0] OP_BRANCH = 4'd4;
  localparam logic [3:0] OP_JAL    = 4'd5;
  localparam logic [3:0] OP_JALR   = 4'd6;
  localparam logic [3:0] OP_LUI    = 4'd7;
  localparam logic [3:0] OP_AUIPC  = 4'd8;

  localparam logic [3:0] FN_ADD  = 4'd0;
  localparam logic [3:0] FN_SUB  = 4'd1;
  localparam logic [3:0] FN_SLL  = 4'd2;
  localparam logic [3:0] FN_SLT  = 4'd3;
  localparam logic [3:0] FN_SLTU = 4'd4;
  localparam logic [3:0] FN_XOR  = 4'd5;
  localparam logic [3:0] FN_SRL  = 4'd6;
  localparam logic [3:0] FN_SRA  = 4'd7;
  localparam logic [3:0] FN_OR   = 4'd8;
  localparam logic [3:0] FN_AND  = 4'd9;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ALU function code to funct3; SUB/SRA share funct3 with ADD/SRL.
  function automatic logic [2:0] alu_funct3(input logic [3:0] fn);
    case (fn)
      FN_SLL:  return 3'b001;
      FN_SLT:  return 3'b010;
      FN_SLTU: return 3'b011;
      FN_XOR:  return 3'b100;
      FN_SRL,
      FN_SRA:  return 3'b101;
      FN_OR:   return 3'b110;
      FN_AND:  return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [6:0] alu_funct7(input logic [3:0] fn);
    return (fn == FN_SUB || fn == FN_SRA) ? 7'b0100000 : 7'b0000000;
  endfunction

  // Immediate packers return the immediate bits already in instruction position.
  function automatic logic [31:0] pack_i(input logic [31:0] imm);
    return {imm[11:0], 20'b0};
  endfunction

  function automatic logic [31:0] pack_s(input logic [31:0] imm);
    return {imm[11:5], 13'b0, imm[4:0], 7'b0};
  endfunction

  function automatic logic [31:0] pack_b(input logic [31:0] imm);
    return {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
  endfunction

  function automatic logic [31:0] pack_u(input logic [31:0] imm);
    return {imm[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] pack_j(input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
  endfunction

  function automatic logic fits_12(input logic [31:0] imm);
    return (imm[31:11] == '0) || (imm[31:11] == '1);
  endfunction

  function automatic logic fits_b(input logic [31:0] imm);
    return ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
  endfunction

  function automatic logic fits_j(input logic [31:0] imm);
    return ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];
  endfunction

  function automatic logic fits_u(input logic [31:0] imm);
    return imm[11:0] == '0;
  endfunction

  function automatic logic fits_shamt(input logic [31:0] imm);
    return imm[31:5] == '0;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// DEPTH-entry FIFO for encoded words; synchronous active-low reset clears the
// pointers only, and the read port shows zero while empty.
module inst_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A push while full is refused even if the same cycle pops.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: storage is left unreset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/encode_inst.sv
// RV32I encoder: packs decoded fields into instruction words and buffers them.
// Optional macro ENCODE_INST_RANGE_CHECK_EN flags immediates that do not fit.
module encode_inst
  import encode_inst_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_class,
  input  logic [3:0]       funct,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] inst_cnt
);

  logic [31:0] raw_word;
  logic [31:0] enc_word;
  logic        field_err;
  logic        range_err;
  logic        enc_err;
  logic        is_shift;
  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic [32:0] fifo_rdata;

  assign is_shift = (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    raw_word  = '0;
    field_err = 1'b0;
    range_err = 1'b0;
    case (op_class)
      OP_R_ALU: begin
        field_err = (funct > FN_AND);
        raw_word  = {alu_funct7(funct), rs2, rs1, alu_funct3(funct), rd, OPC_R};
      end
      OP_I_ALU: begin
        field_err = (funct > FN_AND) || (funct == FN_SUB);
        if (is_shift) begin
          raw_word  = {alu_funct7(funct), imm[4:0], rs1, alu_funct3(funct), rd, OPC_I};
          range_err = !fits_shamt(imm);
        end else begin
          raw_word  = pack_i(imm) | {12'b0, rs1, alu_funct3(funct), rd, OPC_I};
          range_err = !fits_12(imm);
        end
      end
      OP_LOAD: begin
        field_err = !(funct inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5});
        raw_word  = pack_i(imm) | {12'b0, rs1, funct[2:0], rd, OPC_LOAD};
        range_err = !fits_12(imm);
      end
      OP_STORE: begin
        field_err = (funct > 4'd2);
        raw_word  = pack_s(imm) | {7'b0, rs2, rs1, funct[2:0], 5'b0, OPC_STORE};
        range_err = !fits_12(imm);
      end
      OP_BRANCH: begin
        field_err = !(funct inside {4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7});
        raw_word  = pack_b(imm) | {7'b0, rs2, rs1, funct[2:0], 5'b0, OPC_BRANCH};
        range_err = !fits_b(imm);
      end
      OP_JAL: begin
        raw_word  = pack_j(imm) | {20'b0, rd, OPC_JAL};
        range_err = !fits_j(imm);
      end
      OP_JALR: begin
        raw_word  = pack_i(imm) | {12'b0, rs1, 3'b000, rd, OPC_JALR};
        range_err = !fits_12(imm);
      end
      OP_LUI: begin
        raw_word  = pack_u(imm) | {20'b0, rd, OPC_LUI};
        range_err = !fits_u(imm);
      end
      OP_AUIPC: begin
        raw_word  = pack_u(imm) | {20'b0, rd, OPC_AUIPC};
        range_err = !fits_u(imm);
      end
      default: field_err = 1'b1;
    endcase
  end

`ifdef ENCODE_INST_RANGE_CHECK_EN
  assign enc_err = field_err || range_err;
`else
  assign enc_err = field_err;
`endif

  assign enc_word = enc_err ? NOP : raw_word;
  assign in_ready = !fifo_full;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_cnt <= '0;
    end else if (accept) begin
      inst_cnt <= inst_cnt + CNT_W'(1);
    end
  end

  inst_fifo #(
    .DEPTH (DEPTH),
    .W     (33)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .wdata ({enc_err, enc_word}),
    .full  (fifo_full),
    .pop   (out_ready),
    .rdata (fifo_rdata),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_inst  = fifo_rdata[31:0];
  assign out_err   = fifo_rdata[32];

endmodule

// File: tb/tb_encode_inst.sv
// Directed self-checking bench for encode_inst with hand-computed encodings.
module tb_encode_inst;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op_class;
  logic [3:0]  funct;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] inst_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  encode_inst dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_class  (op_class),
    .funct     (funct),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .inst_cnt  (inst_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] cls, input logic [3:0] fn,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im);
    in_valid = v;
    op_class = cls;
    funct    = fn;
    rd       = d;
    rs1      = s1;
    rs2      = s2;
    imm      = im;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_wide_i;
    logic        exp_wide_err;

    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset out_inst", out_inst, 32'd0);
    check("reset out_err", {31'b0, out_err}, 32'd0);
    check("reset inst_cnt", {16'b0, inst_cnt}, 32'd0);
    check("reset in_ready", {31'b0, in_ready}, 32'd1);

    // Streaming with consumer always ready: one-cycle latency per word.
    out_ready = 1'b1;
    drive(1'b1, 4'd0, 4'd1, 5'd3, 5'd2, 5'd1, 32'd0);   // sub x3,x2,x1
    tick();
    check("sub valid", {31'b0, out_valid}, 32'd1);
    check("sub inst", out_inst, 32'h401101B3);
    check("sub err", {31'b0, out_err}, 32'd0);
    check("sub cnt", {16'b0, inst_cnt}, 32'd1);
    drive(1'b1, 4'd0, 4'd8, 5'd9, 5'd1, 5'd2, 32'd0);   // or x9,x1,x2
    tick();
    check("or inst", out_inst, 32'h0020E4B3);
    check("or cnt", {16'b0, inst_cnt}, 32'd2);
    drive(1'b1, 4'd7, 4'd0, 5'd25, 5'd0, 5'd0, 32'hBF45F000);   // lui x25
    tick();
    check("lui inst", out_inst, 32'hBF45FCB7);
    drive(1'b1, 4'd1, 4'd7, 5'd5, 5'd6, 5'd0, 32'd3);   // srai x5,x6,3
    tick();
    check("srai inst", out_inst, 32'h40335293);
    check("srai err", {31'b0, out_err}, 32'd0);
    drive(1'b1, 4'd5, 4'd0, 5'd1, 5'd0, 5'd0, 32'd2048);   // jal x1,2048
    tick();
    check("jal inst", out_inst, 32'h001000EF);
    // addi x1,x0,2048: truncated by default, rejected with the range check.
`ifdef ENCODE_INST_RANGE_CHECK_EN
    exp_wide_i   = 32'h00000013;
    exp_wide_err = 1'b1;
`else
    exp_wide_i   = 32'h80000093;
    exp_wide_err = 1'b0;
`endif
    drive(1'b1, 4'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    tick();
    check("addi 2048 inst", out_inst, exp_wide_i);
    check("addi 2048 err", {31'b0, out_err}, {31'b0, exp_wide_err});
    check("stream cnt", {16'b0, inst_cnt}, 32'd6);
    drive(1'b0, 4'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    check("drained", {31'b0, out_valid}, 32'd0);

    // Backpressure: two accepts fill the FIFO, the third waits.
    out_ready = 1'b0;
    drive(1'b1, 4'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd5);   // addi x1,x0,5
    tick();
    drive(1'b1, 4'd3, 4'd2, 5'd0, 5'd2, 5'd3, 32'd8);   // sw x3,8(x2)
    tick();
    check("bp full in_ready", {31'b0, in_ready}, 32'd0);
    check("bp cnt after 2", {16'b0, inst_cnt}, 32'd8);
    drive(1'b1, 4'd4, 4'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);   // beq x1,x2,-4
    tick();
    tick();
    check("bp held inst", out_inst, 32'h00500093);
    check("bp held valid", {31'b0, out_valid}, 32'd1);
    check("bp cnt held", {16'b0, inst_cnt}, 32'd8);
    out_ready = 1'b1;
    tick();
    check("bp pop no passthru cnt", {16'b0, inst_cnt}, 32'd8);
    check("bp second inst", out_inst, 32'h00312423);
    check("bp ready again", {31'b0, in_ready}, 32'd1);
    tick();
    check("bp third accepted cnt", {16'b0, inst_cnt}, 32'd9);
    check("bp third inst", out_inst, 32'hFE208EE3);
    drive(1'b0, 4'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    check("bp drained", {31'b0, out_valid}, 32'd0);

    // Illegal field combinations become flagged NOPs but are still counted.
    drive(1'b1, 4'd9, 4'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    tick();
    check("illegal class inst", out_inst, 32'h00000013);
    check("illegal class err", {31'b0, out_err}, 32'd1);
    check("illegal class cnt", {16'b0, inst_cnt}, 32'd10);
    drive(1'b1, 4'd1, 4'd1, 5'd1, 5'd2, 5'd0, 32'd4);
    tick();
    check("i-alu sub inst", out_inst, 32'h00000013);
    check("i-alu sub err", {31'b0, out_err}, 32'd1);
    check("i-alu sub cnt", {16'b0, inst_cnt}, 32'd11);
    drive(1'b1, 4'd2, 4'd3, 5'd1, 5'd2, 5'd0, 32'd0);
    tick();
    check("load funct3 err", {31'b0, out_err}, 32'd1);
    drive(1'b1, 4'd2, 4'd4, 5'd7, 5'd8, 5'd0, 32'd16);   // lbu x7,16(x8)
    tick();
    check("lbu inst", out_inst, 32'h01044383);
    check("lbu err", {31'b0, out_err}, 32'd0);

    // Reset with two entries buffered flushes them.
    out_ready = 1'b0;
    drive(1'b1, 4'd0, 4'd9, 5'd1, 5'd2, 5'd3, 32'd0);
    tick();
    tick();
    check("pre-reset full", {31'b0, in_ready}, 32'd0);
    drive(1'b0, 4'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("flush out_valid", {31'b0, out_valid}, 32'd0);
    check("flush cnt", {16'b0, inst_cnt}, 32'd0);
    check("flush in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    tick();
    check("flush nothing emitted", {31'b0, out_valid}, 32'd0);
    check("flush out_inst", out_inst, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
